// File: rtl/ws28xx_bit_encoder.sv
// ws28xx_bit_encoder: serialises pixel bytes MSB first into the single-wire
// WS281x waveform. Each bit is high for h cycles out of a period of p cycles.
// A frame ends with a low latch gap and a one-cycle frame_done_o pulse.
module ws28xx_bit_encoder #(
  parameter int RST_CNT_W    = 16,
  parameter int RESET_CYCLES = 12000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] reg_t0h_time_i,
  input  logic [8:0] reg_t0s_time_i,
  input  logic [7:0] reg_t1h_time_i,
  input  logic [8:0] reg_t1s_time_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  output logic       in_ready_o,
  output logic       bit_code_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  typedef enum logic [1:0] {IDLE, BIT, GAP} state_t;

  localparam logic [RST_CNT_W-1:0] GAP_LAST = RST_CNT_W'(RESET_CYCLES - 1);
  localparam logic [RST_CNT_W-1:0] RCNT_ONE = RST_CNT_W'(1);

  state_t               state;
  logic [6:0]           shreg;     // bits still to send after the current one
  logic                 last_r;
  logic [2:0]           bit_idx;
  logic [8:0]           cnt;
  logic [8:0]           h_r;
  logic [8:0]           p_r;
  logic [RST_CNT_W-1:0] rcnt;
  logic                 bit_code;
  logic                 frame_done;

  logic                 end_bit;
  logic [17:0]          new_t;     // timing for bit 7 of an incoming byte
  logic [17:0]          next_t;    // timing for the next bit of the current byte

  // Period is forced to at least one cycle; high time is clamped to the period.
  function automatic logic [17:0] bit_timing(input logic b,
                                             input logic [7:0] t0h, input logic [8:0] t0s,
                                             input logic [7:0] t1h, input logic [8:0] t1s);
    logic [8:0] th;
    logic [8:0] ts;
    logic [8:0] p;
    logic [8:0] h;
    th = b ? {1'b0, t1h} : {1'b0, t0h};
    ts = b ? t1s : t0s;
    p  = (ts == 9'd0) ? 9'd1 : ts;
    h  = (th > p) ? p : th;
    return {h, p};
  endfunction

  assign new_t  = bit_timing(in_data_i[7], reg_t0h_time_i, reg_t0s_time_i,
                             reg_t1h_time_i, reg_t1s_time_i);
  assign next_t = bit_timing(shreg[6], reg_t0h_time_i, reg_t0s_time_i,
                             reg_t1h_time_i, reg_t1s_time_i);

  assign end_bit      = (cnt == p_r - 9'd1);
  assign in_ready_o   = (state == IDLE) ||
                        ((state == BIT) && end_bit && (bit_idx == 3'd0) && !last_r);
  assign busy_o       = (state != IDLE);
  assign bit_code_o   = bit_code;
  assign frame_done_o = frame_done;

  // Main FSM: byte load, per-bit counting, latch gap. bit_code is computed
  // from the values the counters take next, so the line follows cnt < h.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      shreg      <= '0;
      last_r     <= 1'b0;
      bit_idx    <= '0;
      cnt        <= '0;
      h_r        <= '0;
      p_r        <= '0;
      rcnt       <= '0;
      bit_code   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          bit_code <= 1'b0;
          if (in_valid_i) begin
            shreg    <= in_data_i[6:0];
            last_r   <= in_last_i;
            bit_idx  <= 3'd7;
            cnt      <= '0;
            h_r      <= new_t[17:9];
            p_r      <= new_t[8:0];
            bit_code <= (new_t[17:9] != 9'd0);
            state    <= BIT;
          end
        end
        BIT: begin
          if (!end_bit) begin
            cnt      <= cnt + 9'd1;
            bit_code <= ((cnt + 9'd1) < h_r);
          end else if (bit_idx != 3'd0) begin
            shreg    <= {shreg[5:0], 1'b0};
            bit_idx  <= bit_idx - 3'd1;
            cnt      <= '0;
            h_r      <= next_t[17:9];
            p_r      <= next_t[8:0];
            bit_code <= (next_t[17:9] != 9'd0);
          end else if (!last_r) begin
            if (in_valid_i) begin
              // back-to-back byte: no idle cycle on the line
              shreg    <= in_data_i[6:0];
              last_r   <= in_last_i;
              bit_idx  <= 3'd7;
              cnt      <= '0;
              h_r      <= new_t[17:9];
              p_r      <= new_t[8:0];
              bit_code <= (new_t[17:9] != 9'd0);
            end else begin
              // underrun: park low without a latch gap
              cnt      <= '0;
              bit_code <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            cnt        <= '0;
            rcnt       <= '0;
            bit_code   <= 1'b0;
            frame_done <= (GAP_LAST == '0);
            state      <= GAP;
          end
        end
        GAP: begin
          bit_code <= 1'b0;
          if (rcnt == GAP_LAST) begin
            rcnt  <= '0;
            state <= IDLE;
          end else begin
            rcnt       <= rcnt + RCNT_ONE;
            frame_done <= ((rcnt + RCNT_ONE) == GAP_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws28xx_bit_encoder.sv
// Testbench for ws28xx_bit_encoder: table-driven single-byte frames,
// hand-written multi-cycle sequences and random frames, each compared
// cycle by cycle against a waveform model built from the bit rules.
module tb_ws28xx_bit_encoder;
  localparam int R = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] t0h, t1h;
  logic [8:0] t0s, t1s;
  logic       in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, bit_code, busy, frame_done;

  ws28xx_bit_encoder #(.RST_CNT_W(16), .RESET_CYCLES(R)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reg_t0h_time_i(t0h), .reg_t0s_time_i(t0s),
    .reg_t1h_time_i(t1h), .reg_t1s_time_i(t1s),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last),
    .in_ready_o(in_ready), .bit_code_o(bit_code), .busy_o(busy),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit rec = 1'b0;
  // each sample: {bit_code, in_ready, frame_done, busy}
  logic [3:0] log_q[$];
  logic [3:0] exp_q[$];
  logic [7:0] tx_q[$];

  always @(negedge clk) begin
    if (rec) log_q.push_back({bit_code, in_ready, frame_done, busy});
    if (frame_done) done_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    int t0h, t0s, t1h, t1s;
    int period, highs;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // ---- reference model: a bit is p cycles, the first h of them high ----
  task automatic m_bit(input bit b, input int a0h, input int a0s, input int a1h,
                       input int a1s, input bit rdy_end);
    int th, ts, p, h;
    th = b ? a1h : a0h;
    ts = b ? a1s : a0s;
    p  = (ts == 0) ? 1 : ts;
    h  = (th > p) ? p : th;
    for (int i = 0; i < p; i++)
      exp_q.push_back({(i < h) ? 1'b1 : 1'b0, (rdy_end && i == p - 1) ? 1'b1 : 1'b0, 1'b0, 1'b1});
  endtask

  task automatic m_byte(input logic [7:0] d, input bit last_b);
    for (int k = 7; k >= 0; k--)
      m_bit(d[k], int'(t0h), int'(t0s), int'(t1h), int'(t1s), (k == 0) && !last_b);
  endtask

  task automatic m_gap();
    for (int i = 0; i < R; i++) exp_q.push_back({1'b0, 1'b0, (i == R - 1) ? 1'b1 : 1'b0, 1'b1});
    exp_q.push_back(4'b0100);
  endtask

  task automatic m_start();
    exp_q.delete();
    exp_q.push_back(4'b0100);
  endtask

  // ---- drive tx_q as one stream; optionally retime t0s mid first byte ----
  task automatic drive_frame(input bit final_last, input int chg_after, input int chg_val);
    int n;
    bit ok;
    n = tx_q.size();
    @(posedge clk); #1;
    log_q.delete();
    rec = 1'b1;
    in_valid = 1'b1;
    in_data = tx_q[0];
    in_last = final_last && (n == 1);
    for (int j = 0; j < n; j++) begin
      ok = 1'b0;
      for (int w = 0; w < 4000 && !ok; w++) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
      end
      check("handshake", int'(ok), 1);
      @(posedge clk); #1;
      if (j + 1 < n) begin
        in_data = tx_q[j + 1];
        in_last = final_last && (j + 2 == n);
      end else begin
        in_valid = 1'b0;
        in_last = 1'b0;
      end
      if (j == 0 && chg_after >= 0) begin
        repeat (chg_after) @(posedge clk);
        #1 t0s = 9'(chg_val);
      end
    end
    ok = 1'b0;
    for (int w = 0; w < exp_q.size() + 200 && !ok; w++) begin
      @(negedge clk);
      if (log_q.size() >= exp_q.size()) ok = 1'b1;
    end
    #1 rec = 1'b0;
    check("capture length", int'(ok), 1);
  endtask

  task automatic compare_wave(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) mism++;
    check({"wave ", name}, mism, 0);
  endtask

  function automatic int count_field(input int fld, input int upto);
    int c;
    c = 0;
    for (int i = 0; i < upto && i < log_q.size(); i++)
      if (log_q[i][fld]) c++;
    return c;
  endfunction

  task automatic set_timing(input int a0h, input int a0s, input int a1h, input int a1s);
    t0h = 8'(a0h); t0s = 9'(a0s); t1h = 8'(a1h); t1s = 9'(a1s);
  endtask

  initial begin
    int d0;
    int nb;
    bit fl;
    tbl[0] = '{8'hA5, 10, 40, 30, 40, 320, 160};
    tbl[1] = '{8'hF0, 0, 0, 50, 40, 164, 160};
    tbl[2] = '{8'hFF, 10, 40, 30, 40, 320, 240};
    tbl[3] = '{8'h00, 10, 40, 30, 40, 320, 80};
    tbl[4] = '{8'h3C, 5, 7, 7, 7, 56, 48};
    tbl[5] = '{8'h81, 200, 100, 255, 511, 1622, 1110};

    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    set_timing(10, 40, 30, 40);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset bit_code", int'(bit_code), 0);
    check("reset busy", int'(busy), 0);
    check("reset frame_done", int'(frame_done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle ready", int'(in_ready), 1);

    // table: single-byte frames with last=1
    for (int i = 0; i < 6; i++) begin
      set_timing(tbl[i].t0h, tbl[i].t0s, tbl[i].t1h, tbl[i].t1s);
      m_start(); m_byte(tbl[i].data, 1'b1); m_gap();
      tx_q = '{tbl[i].data};
      d0 = done_cnt;
      drive_frame(1'b1, -1, 0);
      compare_wave($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d period", i), count_field(0, exp_q.size()) - R, tbl[i].period);
      check($sformatf("tbl%0d highs", i), count_field(3, exp_q.size()), tbl[i].highs);
      check($sformatf("tbl%0d done pulses", i), done_cnt - d0, 1);
      $display("tbl%0d byte %02h period %0d highs %0d", i, tbl[i].data,
               count_field(0, exp_q.size()) - R, count_field(3, exp_q.size()));
    end

    // back-to-back bytes: FF then 00 with valid held
    set_timing(10, 40, 30, 40);
    m_start(); m_byte(8'hFF, 1'b0); m_byte(8'h00, 1'b1); m_gap();
    tx_q = '{8'hFF, 8'h00};
    drive_frame(1'b1, -1, 0);
    compare_wave("ff_00");
    check("ff_00 ready cycles", count_field(2, 641), 2);
    check("ff_00 contiguous period", count_field(0, exp_q.size()) - R, 640);
    $display("ff_00 ready %0d period %0d", count_field(2, 641), count_field(0, exp_q.size()) - R);

    // underrun: 0x80 not last, nothing follows
    m_start(); m_byte(8'h80, 1'b0); exp_q.push_back(4'b0100);
    tx_q = '{8'h80};
    d0 = done_cnt;
    drive_frame(1'b0, -1, 0);
    compare_wave("underrun");
    check("underrun no done", done_cnt - d0, 0);
    $display("underrun samples %0d", log_q.size());

    // t0s changed mid-bit during bit 7 of 0x00
    set_timing(10, 40, 30, 40);
    m_start();
    m_bit(1'b0, 10, 40, 30, 40, 1'b0);
    for (int k = 0; k < 7; k++) m_bit(1'b0, 10, 20, 30, 40, 1'b0);
    m_gap();
    tx_q = '{8'h00};
    drive_frame(1'b1, 10, 20);
    compare_wave("retime");
    check("retime period", count_field(0, exp_q.size()) - R, 180);
    $display("retime period %0d", count_field(0, exp_q.size()) - R);

    // reset during bit 3 of a byte
    set_timing(10, 40, 30, 40);
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    repeat (4 * 40 + 5) @(posedge clk);
    #1 check("midbyte busy before reset", int'(busy), 1);
    rst_n = 1'b0;
    #1 check("midbyte reset bit_code", int'(bit_code), 0);
    check("midbyte reset busy", int'(busy), 0);
    d0 = done_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (R + 400) @(posedge clk);
    check("midbyte no done", done_cnt - d0, 0);
    @(negedge clk);
    check("midbyte ready after release", int'(in_ready), 1);
    $display("reset mid-byte checked");

    // reset during the latch gap
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    repeat (320 + 10) @(posedge clk);
    #1 check("gap busy before reset", int'(busy), 1);
    check("gap line low", int'(bit_code), 0);
    rst_n = 1'b0;
    #1 check("gap reset busy", int'(busy), 0);
    d0 = done_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (R + 20) @(posedge clk);
    check("gap no done", done_cnt - d0, 0);
    @(negedge clk);
    check("gap ready after release", int'(in_ready), 1);
    $display("reset mid-gap checked");

    // random frames
    for (int f = 0; f < 8; f++) begin
      set_timing($urandom_range(0, 40), $urandom_range(0, 50),
                 $urandom_range(0, 60), $urandom_range(0, 50));
      nb = $urandom_range(1, 3);
      fl = ($urandom_range(0, 3) != 0);
      tx_q.delete();
      m_start();
      for (int b = 0; b < nb; b++) begin
        tx_q.push_back(8'($urandom));
        m_byte(tx_q[b], fl && (b == nb - 1));
      end
      if (fl) m_gap(); else exp_q.push_back(4'b0100);
      d0 = done_cnt;
      drive_frame(fl, -1, 0);
      compare_wave($sformatf("rand%0d", f));
      check($sformatf("rand%0d done pulses", f), done_cnt - d0, fl ? 1 : 0);
      $display("rand%0d bytes %0d last %0d t0 %0d/%0d t1 %0d/%0d samples %0d",
               f, nb, fl, t0h, t0s, t1h, t1s, exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
